pic_io_port: RTL and testbench

- Parametrised, clocked PIC16F84-style bidirectional I/O port.
- Replaces the single-bit combinational output gate with a full port:
  - TRIS register and output data latch
  - input synchroniser
  - read path
  - interrupt-on-change (IOC) detection on a configurable pin subset
- Sits between the core's register-file bus (PORTx/TRISx accesses) and the pin-level model.
- One instance per port: PORTA with WIDTH=5, IOC_MASK=0; PORTB with WIDTH=8, IOC_MASK=8'hF0.

---
 rtl/pic_port_pkg.sv | 20 ++
 rtl/pic_sync_ff.sv | 37 +++
 rtl/pic_io_port.sv | 87 ++++++++
 tb/tb_pic_io_port.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pic_port_pkg.sv
// ============================================================================
// Module      : pic_port_pkg
// Description : Shared reset values and per-port defaults for pic_io_port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pic_port_pkg;

    localparam logic [7:0] PIC_TRIS_RST   = 8'hFF;
    localparam logic [7:0] PIC_LATCH_RST  = 8'h00;

    localparam int         PORTA_WIDTH    = 5;
    localparam logic [7:0] PORTA_IOC_MASK = 8'h00;
    localparam int         PORTB_WIDTH    = 8;
    localparam logic [7:0] PORTB_IOC_MASK = 8'hF0;

endpackage : pic_port_pkg

`default_nettype wire

// File: rtl/pic_sync_ff.sv
// ============================================================================
// Module      : pic_sync_ff
// Description : Multi-bit shift-register synchroniser, async reset to 0.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pic_sync_ff #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int s = 1; s < STAGES; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule : pic_sync_ff

`default_nettype wire

// File: rtl/pic_io_port.sv
// ============================================================================
// Module      : pic_io_port
// Description : PIC16F84-style bidirectional I/O port with TRIS, output
//               latch, input synchroniser and interrupt-on-change.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pic_io_port
    import pic_port_pkg::*;
#(
    parameter int         WIDTH       = PORTB_WIDTH,
    parameter logic [7:0] IOC_MASK    = PORTB_IOC_MASK,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wr_port,
    input  logic             wr_tris,
    input  logic             rd_port,
    input  logic             ioc_clr,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] tris_q,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             ioc_flag
);

    localparam logic [WIDTH-1:0] c_ioc_mask   = IOC_MASK[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_tris_rst   = PIC_TRIS_RST[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_latch_rst  = PIC_LATCH_RST[WIDTH-1:0];

    logic [WIDTH-1:0] r_tris;
    logic [WIDTH-1:0] r_latch;
    logic [WIDTH-1:0] r_ioc_ref;
    logic             r_ioc_flag;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_monitor;
    logic             w_mismatch;

    pic_sync_ff #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (pin_in),
        .o_q   (w_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tris  <= c_tris_rst;
            r_latch <= c_latch_rst;
        end else begin
            if (wr_tris) r_tris  <= wdata;
            if (wr_port) r_latch <= wdata;
        end
    end

    // Only input pins are watched; a pin turned output drops out immediately.
    assign w_monitor  = c_ioc_mask & r_tris;
    assign w_mismatch = |((w_sync ^ r_ioc_ref) & w_monitor);

    // A live mismatch overrides a clear so a change cannot be lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ioc_ref  <= '0;
            r_ioc_flag <= 1'b0;
        end else begin
            if (rd_port) r_ioc_ref <= w_sync;
            if (w_mismatch)   r_ioc_flag <= 1'b1;
            else if (ioc_clr) r_ioc_flag <= 1'b0;
        end
    end

    assign rdata    = w_sync;
    assign tris_q   = r_tris;
    assign pin_oe   = ~r_tris;
    assign pin_out  = r_latch & ~r_tris;
    assign ioc_flag = r_ioc_flag;

endmodule : pic_io_port

`default_nettype wire

// File: tb/tb_pic_io_port.sv
// ============================================================================
// Module      : tb_pic_io_port
// Description : Directed and randomized checks of pic_io_port against a
//               behavioural port model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pic_io_port;

    localparam int         W    = 8;
    localparam logic [7:0] MASK = 8'hF0;
    localparam int         SS   = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] wdata;
    logic         wr_port, wr_tris, rd_port, ioc_clr;
    logic [W-1:0] pin_in;
    logic [W-1:0] rdata, tris_q, pin_out, pin_oe;
    logic         ioc_flag;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] m_tris, m_latch, m_ref;
    logic         m_flag;
    logic [W-1:0] m_hist[$];
    logic [W-1:0] ext;

    pic_io_port #(
        .WIDTH       (W),
        .IOC_MASK    (MASK),
        .SYNC_STAGES (SS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wdata    (wdata),
        .wr_port  (wr_port),
        .wr_tris  (wr_tris),
        .rd_port  (rd_port),
        .ioc_clr  (ioc_clr),
        .pin_in   (pin_in),
        .rdata    (rdata),
        .tris_q   (tris_q),
        .pin_out  (pin_out),
        .pin_oe   (pin_oe),
        .ioc_flag (ioc_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] m_rdata();
        return m_hist[SS-1];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".tris_q"},   tris_q,         m_tris);
        chk({tag, ".pin_oe"},   pin_oe,         ~m_tris);
        chk({tag, ".pin_out"},  pin_out,        m_latch & ~m_tris);
        chk({tag, ".rdata"},    rdata,          m_rdata());
        chk({tag, ".ioc_flag"}, {7'd0, ioc_flag}, {7'd0, m_flag});
    endtask

    task automatic model_reset();
        m_tris  = '1;
        m_latch = '0;
        m_ref   = '0;
        m_flag  = 1'b0;
        m_hist.delete();
        for (int i = 0; i < SS; i++) m_hist.push_back('0);
    endtask

    // Driven pins loop back their own output level.
    task automatic drive_pins();
        pin_in = (ext & m_tris) | (m_latch & ~m_tris);
    endtask

    task automatic tick(input string tag);
        logic         mis;
        logic [W-1:0] n_tris, n_latch, n_ref;
        logic         n_flag;
        mis     = |((m_rdata() ^ m_ref) & MASK & m_tris);
        n_flag  = mis ? 1'b1 : (ioc_clr ? 1'b0 : m_flag);
        n_ref   = rd_port ? m_rdata() : m_ref;
        n_tris  = wr_tris ? wdata : m_tris;
        n_latch = wr_port ? wdata : m_latch;
        @(posedge clk);
        #1;
        m_hist.push_front(pin_in);
        void'(m_hist.pop_back());
        m_flag  = n_flag;
        m_ref   = n_ref;
        m_tris  = n_tris;
        m_latch = n_latch;
        wr_port = 1'b0; wr_tris = 1'b0; rd_port = 1'b0; ioc_clr = 1'b0;
        drive_pins();
        check_all(tag);
    endtask

    task automatic op(input string tag, input logic wp, input logic wt,
                      input logic rd, input logic clr, input logic [W-1:0] wd);
        wr_port = wp; wr_tris = wt; rd_port = rd; ioc_clr = clr; wdata = wd;
        tick(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) op(tag, 0, 0, 0, 0, '0);
    endtask

    // Pull reset between edges with strobes possibly pending.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".assert"});
        @(posedge clk);
        #1;
        check_all({tag, ".hold"});
        @(negedge clk);
        rst_n = 1'b1;
        wr_port = 1'b0; wr_tris = 1'b0; rd_port = 1'b0; ioc_clr = 1'b0;
        drive_pins();
    endtask

    initial begin
        rst_n = 1'b0;
        wdata = '0; wr_port = 0; wr_tris = 0; rd_port = 0; ioc_clr = 0;
        ext = '0;
        model_reset();
        drive_pins();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_rst", 2);

        // Simultaneous writes both load, then reset mid-write discards the strobe
        op("both_wr", 1, 1, 0, 0, 8'h3C);
        chk("both_wr.tris_const", tris_q, 8'h3C);
        wr_port = 1'b1; wdata = 8'h55;
        async_reset("mid_wr_rst");
        chk("rst.tris_const",  tris_q,  8'hFF);
        chk("rst.oe_const",    pin_oe,  8'h00);
        chk("rst.out_const",   pin_out, 8'h00);
        idle("rst_hold", 3);

        // Drive path with retained latch
        op("wr_port_a5", 1, 0, 0, 0, 8'hA5);
        op("wr_tris_0f", 0, 1, 0, 0, 8'h0F);
        chk("drive.oe_f0",  pin_oe,  8'hF0);
        chk("drive.out_a0", pin_out, 8'hA0);
        op("wr_tris_00", 0, 1, 0, 0, 8'h00);
        chk("drive.out_a5", pin_out, 8'hA5);
        op("wr_tris_ff", 0, 1, 0, 0, 8'hFF);
        idle("settle", 4);
        op("rd_clean", 0, 0, 1, 0, '0);
        op("clr_clean", 0, 0, 0, 1, '0);
        idle("clean", 2);

        // Synchroniser latency
        ext = 8'h3C; drive_pins();
        op("sync1", 0, 0, 0, 0, '0);
        chk("sync.before", rdata, 8'h00);
        op("sync2", 0, 0, 0, 0, '0);
        chk("sync.after", rdata, 8'h3C);
        op("rd_3c", 0, 0, 1, 0, '0);
        op("clr_3c", 0, 0, 0, 1, '0);
        chk("sync.flag_cleared", {7'd0, ioc_flag}, 8'h00);
        ext = 8'h00; drive_pins();
        idle("back0", 3);
        op("rd_00", 0, 0, 1, 0, '0);
        op("clr_00", 0, 0, 0, 1, '0);
        idle("quiet", 1);

        // Unmasked pin toggling
        ext = 8'h02; drive_pins(); idle("bit1_hi", 4);
        ext = 8'h00; drive_pins(); idle("bit1_lo", 4);
        chk("bit1.no_flag", {7'd0, ioc_flag}, 8'h00);

        // Masked pin rise sets flag on the third edge
        ext = 8'h40; drive_pins();
        op("b6_e1", 0, 0, 0, 0, '0);
        op("b6_e2", 0, 0, 0, 0, '0);
        chk("b6.e2_flag0", {7'd0, ioc_flag}, 8'h00);
        op("b6_e3", 0, 0, 0, 0, '0);
        chk("b6.e3_flag1", {7'd0, ioc_flag}, 8'h01);

        // Clear ordering
        op("clr_alone", 0, 0, 0, 1, '0);
        chk("sticky.clr_alone", {7'd0, ioc_flag}, 8'h01);
        op("rd_40", 0, 0, 1, 0, '0);
        op("clr_after_rd", 0, 0, 0, 1, '0);
        idle("stay0", 3);
        chk("sticky.cleared", {7'd0, ioc_flag}, 8'h00);

        // Output pin excluded from IOC
        op("tris_7f", 0, 1, 0, 0, 8'h7F);
        op("port_80", 1, 0, 0, 0, 8'h80);
        idle("loop", 4);
        chk("excl.flag0",   {7'd0, ioc_flag}, 8'h00);
        chk("excl.rdata7",  rdata & 8'h80,    8'h80);

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 75) begin
                wr_port = 1'b1; wr_tris = 1'b1; wdata = 8'($urandom);
                async_reset("rand_rst");
            end
            if ($urandom_range(0, 5) == 0) begin
                ext = 8'($urandom);
                drive_pins();
            end
            op("rand",
               $urandom_range(0, 9) == 0,
               $urandom_range(0, 11) == 0,
               $urandom_range(0, 6) == 0,
               $urandom_range(0, 6) == 0,
               8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pic_io_port

`default_nettype wire
